emern_sprite_layer: RTL
=======================

EMERN_SPRITE_LAYER -- requirements
Module: emern_sprite_layer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single pixel clock (25.175 MHz nominal), shared with the VGA timing generator.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL have the port row, input, 10 bits: current line from the timing generator, 0..524.
REQ-004 The block SHALL have the port col, input, 10 bits: current pixel from the timing generator, 0..799.
REQ-005 The block SHALL have the port screen_inactive, input, 1 bit: high outside the 640x480 visible area.
REQ-006 The block SHALL have the ports h_sync_in and v_sync_in, inputs, 1 bit each: active-low syncs from the timing generator.
REQ-007 The block SHALL have the port cfg_valid, input, 1 bit: a config write is offered.
REQ-008 The block SHALL have the port cfg_ready, output, 1 bit: the block can accept a write.
REQ-009 The block SHALL have the port cfg_addr, input, 3 bits: shadow register address.
REQ-010 The block SHALL have the port cfg_data, input, 8 bits: write data.
REQ-011 The block SHALL have the port rgb, output, 6 bits: {R[1:0],G[1:0],B[1:0]}, registered.
REQ-012 The block SHALL have the ports h_sync and v_sync, outputs, 1 bit each: the input syncs delayed to align with rgb.
REQ-013 The block SHALL have the port frame_start, output, 1 bit: one-cycle pulse on the commit cycle.

Function
REQ-014 The block SHALL provide a shadow register map with these addresses: 0 = x[7:0]; 1 = x[9:8] (data[1:0]); 2 = y[7:0]; 3 = y[9:8]; 4 = fg colour (data[5:0]); 5 = bg colour; 6 = {enable=data[2], scale=data[1:0]}; 7 = bitmap row write.
REQ-015 A write to address 7 SHALL store cfg_data in shadow bitmap row[ptr], then increment ptr, wrapping 7->0.
REQ-016 A write to any of addresses 0-6 SHALL reset ptr to 0.
REQ-017 A write SHALL be accepted only in a cycle with cfg_valid & cfg_ready, and SHALL update its shadow register at the next clk edge.
REQ-018 Unused data bits SHALL be ignored.
REQ-019 A commit cycle SHALL be defined as the cycle in which row==480 and col==0 (first vblank pixel).
REQ-020 In a commit cycle, all shadow registers and the bitmap SHALL copy into the active set, and frame_start SHALL be asserted during that same cycle.
REQ-021 ptr SHALL be unaffected by a commit.
REQ-022 cfg_ready SHALL be 0 during the commit cycle and 1 at all other times after reset.
REQ-023 A write accepted in the cycle before the commit cycle SHALL be included in that commit.
REQ-024 The block SHALL compute hit_x as col >= ax and (col - ax) < (8 << ascale), using 10-bit subtraction only after the >= test, so there is no wrap-around hit.
REQ-025 The block SHALL compute hit_y with the same rule on row and ay.
REQ-026 The bitmap column index SHALL be ix = (col - ax) >> ascale, and the bitmap row index SHALL be iy = (row - ay) >> ascale.
REQ-027 The bitmap pixel SHALL be bitmap[iy][7 - ix], so that the MSB is the leftmost pixel.
REQ-028 The block SHALL compute the colour as follows: if screen_inactive, 0; otherwise, if aenable & hit_x & hit_y & pixel bit, afg; otherwise, abg.
REQ-029 The latency from row/col/screen_inactive to rgb SHALL be exactly 1 clock.
REQ-030 h_sync and v_sync SHALL be the input syncs registered once, so they stay aligned with rgb.
REQ-031 Sprites SHALL be clipped, not wrapped: a sprite at x=636 with scale 0 SHALL show only cols 636-639, and cols 0-3 SHALL be unaffected.
REQ-032 The sprite size SHALL be 8, 16, 32 or 64 px for scale 0, 1, 2 or 3 respectively.
REQ-033 Active registers SHALL change only in a commit cycle, so there is no tearing within a visible frame.

Reset
REQ-034 While rst_n=0 at a clk edge, the shadow and active registers SHALL reset to these values: x=0, y=0, fg=6'h3F, bg=6'h00, scale=0, enable=0, bitmap rows=8'h00, ptr=0.
REQ-035 While rst_n=0 at a clk edge, the outputs SHALL reset to these values: rgb=0, h_sync=1, v_sync=1, frame_start=0, cfg_ready=1.
REQ-036 A reset mid-frame or mid-bitmap-load SHALL discard all pending shadow writes.
REQ-037 After a reset, the first commit SHALL occur at the next row==480, col==0.
REQ-038 The block SHALL have no asynchronous paths.

Verification
REQ-039 The bench SHALL cover basic hit: write x=100, y=50, fg=6'h30, enable=1, scale=0, bitmap row0=8'h80 and rows1-7=0, then let a commit occur -> in the next frame, rgb=6'h30 one cycle after (row=50, col=100); rgb=abg at (50,101); rgb=abg at (51,100).
REQ-040 The bench SHALL cover scale: with the same sprite and scale=2 -> rgb=fg for col 100..103 and row 50..53; rgb=bg at col 104 of row 50.
REQ-041 The bench SHALL cover commit and handshake: hold cfg_valid=1 across the commit cycle -> cfg_ready=0 only at (480,0), and frame_start=1 in the same cycle; the write is accepted the following cycle, and that write becomes active in the next frame only.
REQ-042 The bench SHALL cover no tearing: change x via the shadow registers at row=200 -> rows 200-479 of the current frame still use the old x.
REQ-043 The bench SHALL cover clip and blanking: x=636 -> fg appears at cols 636-639 only, and rgb=0 for cols 640-799 and rows 480-524 regardless of bg.
REQ-044 The bench SHALL cover mid-load reset: write 3 bitmap rows, pulse rst_n low for 1 cycle, then write 1 bitmap row -> that row lands in row0 (ptr=0), and the active bitmap is all zeros until the next commit.

Source files
------------

// File: rtl/emern_sprite_layer.sv
// Single 8x8 monochrome sprite overlay with double-buffered (shadow/active) configuration.
// Latency: row/col/screen_inactive and syncs to rgb/h_sync/v_sync is exactly 1 clk.
// Backpressure: cfg_ready drops only in the commit cycle (row 480, col 0); all other cycles accept.
module emern_sprite_layer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] row,
   input  logic [9:0] col,
   input  logic       screen_inactive,
   input  logic       h_sync_in,
   input  logic       v_sync_in,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic [5:0] rgb,
   output logic       h_sync,
   output logic       v_sync,
   output logic       frame_start
);

   // shadow set, written by the config port
   logic [9:0] sx, sy;
   logic [5:0] sfg, sbg;
   logic       sen;
   logic [1:0] sscale;
   logic [7:0] sbm [8];
   logic [2:0] ptr;

   // active set, used for drawing; only changes on a commit
   logic [9:0] ax, ay;
   logic [5:0] afg, abg;
   logic       aen;
   logic [1:0] ascale;
   logic [7:0] abm [8];

   logic       commit;
   logic       wr;
   logic [9:0] dx, dy, size;
   logic       hit_x, hit_y, pix;
   logic [2:0] ix, iy;
   logic [5:0] colour;

   // first vblank pixel is the only point where shadow state is published
   assign commit      = (row == 10'd480) && (col == 10'd0);
   assign cfg_ready   = ~commit | ~rst_n;
   assign frame_start = commit & rst_n;
   assign wr          = cfg_valid & ~commit;

   // shadow register writes and bitmap row pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sx     <= 10'd0;
         sy     <= 10'd0;
         sfg    <= 6'h3F;
         sbg    <= 6'h00;
         sen    <= 1'b0;
         sscale <= 2'd0;
         ptr    <= 3'd0;
         for (int i = 0; i < 8; i++) sbm[i] <= 8'h00;
      end else if (wr) begin
         if (cfg_addr == 3'd7) begin
            sbm[ptr] <= cfg_data;
            ptr      <= ptr + 3'd1;
         end else begin
            ptr <= 3'd0;
         end
         case (cfg_addr)
            3'd0: sx[7:0] <= cfg_data;
            3'd1: sx[9:8] <= cfg_data[1:0];
            3'd2: sy[7:0] <= cfg_data;
            3'd3: sy[9:8] <= cfg_data[1:0];
            3'd4: sfg     <= cfg_data[5:0];
            3'd5: sbg     <= cfg_data[5:0];
            3'd6: begin
               sen    <= cfg_data[2];
               sscale <= cfg_data[1:0];
            end
            default: ;
         endcase
      end
   end

   // copy shadow into active set in the commit cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ax     <= 10'd0;
         ay     <= 10'd0;
         afg    <= 6'h3F;
         abg    <= 6'h00;
         aen    <= 1'b0;
         ascale <= 2'd0;
         for (int i = 0; i < 8; i++) abm[i] <= 8'h00;
      end else if (commit) begin
         ax     <= sx;
         ay     <= sy;
         afg    <= sfg;
         abg    <= sbg;
         aen    <= sen;
         ascale <= sscale;
         for (int i = 0; i < 8; i++) abm[i] <= sbm[i];
      end
   end

   // hit test and bitmap lookup; the >= test guards the subtraction so nothing wraps
   always_comb begin
      size  = 10'd8 << ascale;
      dx    = col - ax;
      dy    = row - ay;
      hit_x = (col >= ax) && (dx < size);
      hit_y = (row >= ay) && (dy < size);
      case (ascale)
         2'd0:    begin ix = dx[2:0]; iy = dy[2:0]; end
         2'd1:    begin ix = dx[3:1]; iy = dy[3:1]; end
         2'd2:    begin ix = dx[4:2]; iy = dy[4:2]; end
         default: begin ix = dx[5:3]; iy = dy[5:3]; end
      endcase
      pix = abm[iy][3'd7 - ix];
      if (screen_inactive)
         colour = 6'h00;
      else if (aen && hit_x && hit_y && pix)
         colour = afg;
      else
         colour = abg;
   end

   // output register keeps rgb and syncs aligned
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rgb    <= 6'h00;
         h_sync <= 1'b1;
         v_sync <= 1'b1;
      end else begin
         rgb    <= colour;
         h_sync <= h_sync_in;
         v_sync <= v_sync_in;
      end
   end

endmodule
